// File: rtl/fetch_queue_if.sv
// Fetch-stage bus bundle: instruction-memory read port 0, writeback redirect and
// BTB update, and the decode-side instruction stream (valid/ready).
interface fetch_queue_if;
    logic [14:0] mem_raddr;
    logic [15:0] mem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        btb_wen;
    logic [15:0] btb_pc;
    logic [15:0] btb_target;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pc;
    logic [15:0] out_insn;
    logic [15:0] out_pred_pc;

    // Handshake: the head entry moves to decode on a posedge where out_valid and
    // out_ready are both 1; out_valid never depends on out_ready.
    modport master (
        output mem_raddr, out_valid, out_pc, out_insn, out_pred_pc,
        input  mem_rdata, redirect_valid, redirect_pc, btb_wen, btb_pc,
               btb_target, out_ready
    );

    modport slave (
        input  mem_raddr, out_valid, out_pc, out_insn, out_pred_pc,
        output mem_rdata, redirect_valid, redirect_pc, btb_wen, btb_pc,
               btb_target, out_ready
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Fetch stage: PC register, untagged direct-mapped BTB prediction, one in-flight
// memory read and a small instruction FIFO towards decode.
module fetch_queue_unit #(
    parameter int unsigned BTB_BITS = 10,
    parameter int unsigned QDEPTH   = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input logic           clk,
    input logic           rst_n,
    fetch_queue_if.master fq
);
    localparam int unsigned PW   = $clog2(QDEPTH);
    localparam int unsigned CW   = PW + 1;
    localparam int unsigned NBTB = 1 << BTB_BITS;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(QDEPTH);

    logic [15:0]   pc_q, pc_d;
    logic          req_v_q, req_v_d;
    logic [15:0]   req_pc_q, req_pc_d;
    logic [15:0]   req_pred_q, req_pred_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [15:0]   fifo_pc_q   [QDEPTH];
    logic [15:0]   fifo_insn_q [QDEPTH];
    logic [15:0]   fifo_pred_q [QDEPTH];

    logic [NBTB-1:0] btb_v_q;
    logic [15:0]     btb_tgt_q [NBTB];

    logic [BTB_BITS-1:0] rd_idx;
    logic [BTB_BITS-1:0] wr_idx;
    logic [15:0]         pred;
    logic                issue;
    logic                push;
    logic                pop;
    logic                unused_btb_pc_bits;

    assign rd_idx = pc_q[BTB_BITS:1];
    assign wr_idx = fq.btb_pc[BTB_BITS:1];
    assign unused_btb_pc_bits = ^{fq.btb_pc[15:BTB_BITS+1], fq.btb_pc[0]};

    assign pred  = btb_v_q[rd_idx] ? btb_tgt_q[rd_idx] : pc_q + 16'd2;
    // The in-flight word reserves a slot; a same-cycle pop earns no credit.
    assign issue = ({1'b0, count_q} + {{CW{1'b0}}, req_v_q}) < DEPTH_C;
    assign push  = req_v_q & ~fq.redirect_valid;
    assign pop   = (count_q != '0) & fq.out_ready;

    always_comb begin
        pc_d       = pc_q;
        req_v_d    = 1'b0;
        req_pc_d   = req_pc_q;
        req_pred_d = req_pred_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (fq.redirect_valid) begin
            pc_d     = fq.redirect_pc & 16'hFFFE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) begin
                req_v_d    = 1'b1;
                req_pc_d   = pc_q;
                req_pred_d = pred;
                pc_d       = pred;
            end
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            req_v_q    <= 1'b0;
            req_pc_q   <= '0;
            req_pred_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            btb_v_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            req_v_q    <= req_v_d;
            req_pc_q   <= req_pc_d;
            req_pred_q <= req_pred_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            if (fq.btb_wen) btb_v_q[wr_idx] <= 1'b1;
        end
    end

    // Storage arrays carry no reset; their contents are qualified by count/valid.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            fifo_pc_q[wr_ptr_q]   <= req_pc_q;
            fifo_insn_q[wr_ptr_q] <= fq.mem_rdata;
            fifo_pred_q[wr_ptr_q] <= req_pred_q;
        end
        if (rst_n && fq.btb_wen) btb_tgt_q[wr_idx] <= fq.btb_target;
    end

    assign fq.mem_raddr   = pc_q[15:1];
    assign fq.out_valid   = (count_q != '0);
    assign fq.out_pc      = fq.out_valid ? fifo_pc_q[rd_ptr_q]   : 16'h0000;
    assign fq.out_insn    = fq.out_valid ? fifo_insn_q[rd_ptr_q] : 16'h0000;
    assign fq.out_pred_pc = fq.out_valid ? fifo_pred_q[rd_ptr_q] : 16'h0000;
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: transaction-level model of the fetch queue checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_fetch_queue_unit;
  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  fetch_queue_if bus();

  fetch_queue_unit #(.BTB_BITS(10), .QDEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fq    (bus)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory read port 0: word[k] = 16'h8000 | k, one cycle after the address
  always @(posedge clk) bus.mem_rdata <= 16'h8000 | {1'b0, bus.mem_raddr};

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // model: {pc, insn, pred} entries visible to decode, in order
  logic [47:0] exp_q[$];
  logic [15:0] m_btb[int];
  logic [15:0] m_pc;
  bit          m_inf;
  logic [15:0] m_inf_pc;
  logic [15:0] m_inf_pred;
  bit          m_started;

  always @(posedge clk) begin
    logic [15:0] m_pred;
    int          occ;
    if (!rst_n) begin
      m_pc = 16'h0000;
      m_inf = 1'b0;
      exp_q.delete();
      m_btb.delete();
      m_started = 1'b1;
    end else if (m_started) begin
      m_pred = m_btb.exists(int'(m_pc[10:1])) ? m_btb[int'(m_pc[10:1])] : m_pc + 16'd2;
      occ = exp_q.size() + (m_inf ? 1 : 0);
      if (bus.btb_wen) m_btb[int'(bus.btb_pc[10:1])] = bus.btb_target;
      if (bus.redirect_valid) begin
        m_pc = bus.redirect_pc & 16'hFFFE;
        m_inf = 1'b0;
        exp_q.delete();
      end else begin
        if (exp_q.size() > 0 && bus.out_ready) void'(exp_q.pop_front());
        if (m_inf) exp_q.push_back({m_inf_pc, 16'h8000 | (m_inf_pc >> 1), m_inf_pred});
        if (occ < 4) begin
          m_inf = 1'b1;
          m_inf_pc = m_pc;
          m_inf_pred = m_pred;
          m_pc = m_pred;
        end else begin
          m_inf = 1'b0;
        end
      end
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    logic [47:0] h;
    if (m_started) begin
      chk("m_raddr", {1'b0, bus.mem_raddr}, {1'b0, m_pc[15:1]});
      chk("m_valid", {15'd0, bus.out_valid}, {15'd0, exp_q.size() != 0});
      h = (exp_q.size() != 0) ? exp_q[0] : 48'd0;
      chk("m_pc",   bus.out_pc,      h[47:32]);
      chk("m_insn", bus.out_insn,    h[31:16]);
      chk("m_pred", bus.out_pred_pc, h[15:0]);
    end
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic redirect(input logic [15:0] tgt);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = tgt;
    tick(1);
    bus.redirect_valid = 1'b0;
  endtask

  task automatic reset_pulse(input int n);
    rst_n = 1'b0;
    tick(n);
    rst_n = 1'b1;
  endtask

  logic [15:0] ready_pat;

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    m_started = 1'b0;
    rst_n = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.btb_wen = 1'b0;
    bus.btb_pc = 16'h0000;
    bus.btb_target = 16'h0000;
    bus.out_ready = 1'b1;

    // streaming from reset
    tick(2);
    chk("rst_valid", {15'd0, bus.out_valid}, 16'h0000);
    chk("rst_pc", bus.out_pc, 16'h0000);
    rst_n = 1'b1;
    tick(1);
    chk("c1_valid", {15'd0, bus.out_valid}, 16'h0000);
    tick(1);
    chk("c2_valid", {15'd0, bus.out_valid}, 16'h0001);
    chk("c2_pc", bus.out_pc, 16'h0000);
    chk("c2_insn", bus.out_insn, 16'h8000);
    chk("c2_pred", bus.out_pred_pc, 16'h0002);
    tick(1);
    chk("c3_pc", bus.out_pc, 16'h0002);
    chk("c3_insn", bus.out_insn, 16'h8001);
    tick(2);
    chk("c5_pc", bus.out_pc, 16'h0006);
    chk("c5_pred", bus.out_pred_pc, 16'h0008);

    // backpressure from reset: four entries captured, pc stalls at 8
    bus.out_ready = 1'b0;
    reset_pulse(1);
    tick(8);
    chk("stall_raddr", {1'b0, bus.mem_raddr}, 16'h0004);
    chk("stall_pc", bus.out_pc, 16'h0000);
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      chk("drain_pc", bus.out_pc, 16'(2 * i));
    end

    // redirect with two queued and one in flight
    bus.out_ready = 1'b0;
    reset_pulse(1);
    tick(3);
    redirect(16'h0041);
    bus.out_ready = 1'b1;
    chk("rd_v1", {15'd0, bus.out_valid}, 16'h0000);
    tick(1);
    chk("rd_v2", {15'd0, bus.out_valid}, 16'h0000);
    tick(1);
    chk("rd_pc", bus.out_pc, 16'h0040);
    chk("rd_insn", bus.out_insn, 16'h8020);

    // BTB write together with redirect to 0
    bus.btb_wen = 1'b1;
    bus.btb_pc = 16'h0010;
    bus.btb_target = 16'h0100;
    redirect(16'h0000);
    bus.btb_wen = 1'b0;
    tick(2);
    chk("btb_pc0", bus.out_pc, 16'h0000);
    tick(8);
    chk("btb_pc10", bus.out_pc, 16'h0010);
    chk("btb_pred10", bus.out_pred_pc, 16'h0100);
    tick(1);
    chk("btb_pc100", bus.out_pc, 16'h0100);
    chk("btb_insn100", bus.out_insn, 16'h8080);

    // PC wrap at the top of the address space
    redirect(16'hFFFC);
    tick(2);
    chk("wrap_fffc", bus.out_pc, 16'hFFFC);
    chk("wrap_insn", bus.out_insn, 16'hFFFE);
    tick(1);
    chk("wrap_fffe", bus.out_pc, 16'hFFFE);
    chk("wrap_pred", bus.out_pred_pc, 16'h0000);
    tick(1);
    chk("wrap_0000", bus.out_pc, 16'h0000);
    tick(1);
    chk("wrap_0002", bus.out_pc, 16'h0002);

    // mid-stream reset clears the BTB
    reset_pulse(1);
    chk("mrst_valid", {15'd0, bus.out_valid}, 16'h0000);
    chk("mrst_raddr", {1'b0, bus.mem_raddr}, 16'h0000);
    tick(2);
    chk("mrst_pc0", bus.out_pc, 16'h0000);
    tick(8);
    chk("mrst_pc10", bus.out_pc, 16'h0010);
    chk("mrst_pred10", bus.out_pred_pc, 16'h0012);
    tick(1);
    chk("mrst_pc12", bus.out_pc, 16'h0012);

    // irregular decode backpressure, checked by the model each cycle
    ready_pat = 16'b1011_0010_1110_0101;
    for (int i = 0; i < 16; i++) begin
      bus.out_ready = ready_pat[i];
      if (i == 9) redirect(16'h0200);
      else tick(1);
    end
    bus.out_ready = 1'b1;
    tick(6);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
